// File: rtl/riscv_ex_pkg.sv
// riscv_ex_pkg
// Shared encodings for the execute stage: ALU operation codes, branch funct3
// values, forward-select codes, multiply sub-ops and the multiplier FSM state
// type. Also holds small helpers that map a multiply sub-op to operand
// signedness.
package riscv_ex_pkg;

  // ALUControlE encoding
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  // BranchTypeE encoding (RISC-V funct3)
  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  // ForwardAE / ForwardBE encoding; 2'b11 falls back to the register operand
  localparam logic [1:0] FWD_RD = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // MulOpE encoding
  localparam logic [1:0] MUL_MUL    = 2'b00;
  localparam logic [1:0] MUL_MULH   = 2'b01;
  localparam logic [1:0] MUL_MULHSU = 2'b10;
  localparam logic [1:0] MUL_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_RUN  = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_t;

  // For plain mul only the low half is kept, which is the same for any
  // signedness, so it is treated as signed x signed.
  function automatic logic mul_a_signed(input logic [1:0] op);
    return (op != MUL_MULHU);
  endfunction

  function automatic logic mul_b_signed(input logic [1:0] op);
    return (op == MUL_MUL) || (op == MUL_MULH);
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// seq_multiplier
// Iterative shift-add multiplier. Operands are converted to magnitudes when
// start is seen in IDLE, one add/shift step is done per cycle for XLEN cycles
// in RUN, and in DONE the full 2*XLEN product is presented (negated when the
// operand signs differ).
// Ports:
//   clk, rst      clock and synchronous active-high reset (aborts a multiply)
//   i_start       request; only acted on in IDLE
//   i_op_a/i_op_b XLEN-bit operands
//   i_a_signed    treat i_op_a as two's complement
//   i_b_signed    treat i_op_b as two's complement
//   o_busy        high in IDLE while i_start is high, and throughout RUN
//   o_done        high for the single DONE cycle
//   o_product     2*XLEN product, valid while o_done is high
module seq_multiplier
  import riscv_ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [XLEN-1:0]   i_op_a,
  input  logic [XLEN-1:0]   i_op_b,
  input  logic              i_a_signed,
  input  logic              i_b_signed,
  output logic              o_busy,
  output logic              o_done,
  output logic [2*XLEN-1:0] o_product
);

  localparam int CW = $clog2(XLEN);
  localparam int PW = 2 * XLEN;
  localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);

  mul_state_t      r_state;
  mul_state_t      w_state_next;
  logic [XLEN-1:0] r_mcand;
  logic [PW-1:0]   r_prod;
  logic [CW-1:0]   r_cnt;
  logic            r_neg;

  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic [XLEN:0]   w_step_sum;

  assign w_a_neg = i_a_signed & i_op_a[XLEN-1];
  assign w_b_neg = i_b_signed & i_op_b[XLEN-1];
  // The most negative value maps onto 2^(XLEN-1), which still fits unsigned.
  assign w_a_mag = w_a_neg ? (~i_op_a + XLEN'(1)) : i_op_a;
  assign w_b_mag = w_b_neg ? (~i_op_b + XLEN'(1)) : i_op_b;

  // r_prod = {accumulator, remaining multiplier bits}. Each step adds the
  // multiplicand into the upper half when the current multiplier bit is set,
  // then shifts the whole thing right, carry included.
  assign w_step_sum = {1'b0, r_prod[PW-1:XLEN]} + (r_prod[0] ? {1'b0, r_mcand} : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= MUL_IDLE;
      r_mcand <= '0;
      r_prod  <= '0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        MUL_IDLE: begin
          if (i_start) begin
            r_mcand <= w_a_mag;
            r_prod  <= {{XLEN{1'b0}}, w_b_mag};
            r_cnt   <= '0;
            r_neg   <= w_a_neg ^ w_b_neg;
          end
        end
        MUL_RUN: begin
          r_prod <= {w_step_sum, r_prod[XLEN-1:1]};
          r_cnt  <= r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      MUL_IDLE: begin
        if (i_start) begin
          o_busy       = 1'b1;
          w_state_next = MUL_RUN;
        end
      end
      MUL_RUN: begin
        o_busy = 1'b1;
        if (r_cnt == LAST_STEP) begin
          w_state_next = MUL_DONE;
        end
      end
      MUL_DONE: begin
        o_done       = 1'b1;
        w_state_next = MUL_IDLE;
      end
      default: begin
        w_state_next = MUL_IDLE;
      end
    endcase
  end

  assign o_product = r_neg ? (~r_prod + PW'(1)) : r_prod;

endmodule

// File: rtl/execute_stage_fwd.sv
// execute_stage_fwd
// Pipelined RISC-V execute stage: forwarding muxes, ALU, branch comparator,
// branch/JAL/JALR target adder, iterative multiplier and the EX/MEM pipeline
// register.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   RegWriteE..MulE, BranchTypeE,
//   MulOpE, ALUControlE            decoded controls of the EX instruction
//   ForwardAE/ForwardBE            operand source select (RD, ResultW, ALU_ResultM)
//   RD1_E, RD2_E, Imm_Ext_E,
//   PCE, PCPlus4E, RD_E            ID/EX operands
//   ResultW                        writeback result used as a forward source
//   PCSrcE, PCTargetE              combinational redirect request and target
//   busy_e                         multiplier occupied; upstream must hold
//   *M                             EX/MEM register outputs
module execute_stage_fwd
  import riscv_ex_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteE,
  input  logic              MemWriteE,
  input  logic              ResultSrcE,
  input  logic              ALUSrcE,
  input  logic              BranchE,
  input  logic              JumpE,
  input  logic              JalrE,
  input  logic              MulE,
  input  logic [2:0]        BranchTypeE,
  input  logic [1:0]        MulOpE,
  input  logic [3:0]        ALUControlE,
  input  logic [1:0]        ForwardAE,
  input  logic [1:0]        ForwardBE,
  input  logic [XLEN-1:0]   RD1_E,
  input  logic [XLEN-1:0]   RD2_E,
  input  logic [XLEN-1:0]   Imm_Ext_E,
  input  logic [XLEN-1:0]   PCE,
  input  logic [XLEN-1:0]   PCPlus4E,
  input  logic [REG_AW-1:0] RD_E,
  input  logic [XLEN-1:0]   ResultW,
  output logic              PCSrcE,
  output logic [XLEN-1:0]   PCTargetE,
  output logic              busy_e,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic              ResultSrcM,
  output logic [REG_AW-1:0] RD_M,
  output logic [XLEN-1:0]   PCPlus4M,
  output logic [XLEN-1:0]   WriteDataM,
  output logic [XLEN-1:0]   ALU_ResultM
);

  localparam int SHW = $clog2(XLEN);

  logic              r_reg_write_m;
  logic              r_mem_write_m;
  logic              r_result_src_m;
  logic [REG_AW-1:0] r_rd_m;
  logic [XLEN-1:0]   r_pc_plus4_m;
  logic [XLEN-1:0]   r_write_data_m;
  logic [XLEN-1:0]   r_alu_result_m;

  logic [XLEN-1:0]   w_fwd_a;
  logic [XLEN-1:0]   w_fwd_b;
  logic [XLEN-1:0]   w_src_b;
  logic [SHW-1:0]    w_shamt;
  logic [XLEN-1:0]   w_alu_result;
  logic              w_eq;
  logic              w_lt_s;
  logic              w_lt_u;
  logic              w_taken;
  logic [XLEN-1:0]   w_jalr_sum;

  logic              w_mul_busy;
  logic              w_mul_done;
  logic [2*XLEN-1:0] w_mul_product;
  logic [XLEN-1:0]   w_mul_result;

  // ---------------- forwarding ----------------
  always_comb begin
    case (ForwardAE)
      FWD_W:   w_fwd_a = ResultW;
      FWD_M:   w_fwd_a = r_alu_result_m;
      default: w_fwd_a = RD1_E;
    endcase
  end

  always_comb begin
    case (ForwardBE)
      FWD_W:   w_fwd_b = ResultW;
      FWD_M:   w_fwd_b = r_alu_result_m;
      default: w_fwd_b = RD2_E;
    endcase
  end

  assign w_src_b = ALUSrcE ? Imm_Ext_E : w_fwd_b;
  assign w_shamt = w_src_b[SHW-1:0];

  // ---------------- ALU ----------------
  always_comb begin
    w_alu_result = '0;
    case (ALUControlE)
      ALU_ADD:  w_alu_result = w_fwd_a + w_src_b;
      ALU_SUB:  w_alu_result = w_fwd_a - w_src_b;
      ALU_AND:  w_alu_result = w_fwd_a & w_src_b;
      ALU_OR:   w_alu_result = w_fwd_a | w_src_b;
      ALU_XOR:  w_alu_result = w_fwd_a ^ w_src_b;
      ALU_SLL:  w_alu_result = w_fwd_a << w_shamt;
      ALU_SRL:  w_alu_result = w_fwd_a >> w_shamt;
      ALU_SRA:  w_alu_result = $unsigned($signed(w_fwd_a) >>> w_shamt);
      ALU_SLT:  w_alu_result = {{(XLEN-1){1'b0}}, ($signed(w_fwd_a) < $signed(w_src_b))};
      ALU_SLTU: w_alu_result = {{(XLEN-1){1'b0}}, (w_fwd_a < w_src_b)};
      default:  w_alu_result = '0;
    endcase
  end

  // ---------------- branch compare and target ----------------
  // The comparator always uses the register-side operands, never the immediate.
  assign w_eq   = (w_fwd_a == w_fwd_b);
  assign w_lt_s = ($signed(w_fwd_a) < $signed(w_fwd_b));
  assign w_lt_u = (w_fwd_a < w_fwd_b);

  always_comb begin
    case (BranchTypeE)
      BR_BEQ:  w_taken = w_eq;
      BR_BNE:  w_taken = ~w_eq;
      BR_BLT:  w_taken = w_lt_s;
      BR_BGE:  w_taken = ~w_lt_s;
      BR_BLTU: w_taken = w_lt_u;
      BR_BGEU: w_taken = ~w_lt_u;
      default: w_taken = 1'b0;
    endcase
  end

  assign w_jalr_sum = w_fwd_a + Imm_Ext_E;
  assign PCTargetE  = JalrE ? (w_jalr_sum & ~XLEN'(1)) : (PCE + Imm_Ext_E);
  assign PCSrcE     = (BranchE & w_taken) | JumpE;

  // ---------------- multiplier ----------------
  seq_multiplier #(
    .XLEN (XLEN)
  ) u_mul (
    .clk        (clk),
    .rst        (rst),
    .i_start    (MulE),
    .i_op_a     (w_fwd_a),
    .i_op_b     (w_fwd_b),
    .i_a_signed (mul_a_signed(MulOpE)),
    .i_b_signed (mul_b_signed(MulOpE)),
    .o_busy     (w_mul_busy),
    .o_done     (w_mul_done),
    .o_product  (w_mul_product)
  );

  // MulOpE is still valid in DONE because upstream held ID/EX while busy.
  assign w_mul_result = (MulOpE == MUL_MUL) ? w_mul_product[XLEN-1:0]
                                            : w_mul_product[2*XLEN-1:XLEN];
  assign busy_e = w_mul_busy;

  // ---------------- EX/MEM register ----------------
  // A bubble while the multiplier is busy looks exactly like the reset value.
  always_ff @(posedge clk) begin
    if (rst || w_mul_busy) begin
      r_reg_write_m  <= 1'b0;
      r_mem_write_m  <= 1'b0;
      r_result_src_m <= 1'b0;
      r_rd_m         <= '0;
      r_pc_plus4_m   <= '0;
      r_write_data_m <= '0;
      r_alu_result_m <= '0;
    end else begin
      r_reg_write_m  <= RegWriteE;
      r_mem_write_m  <= MemWriteE;
      r_result_src_m <= ResultSrcE;
      r_rd_m         <= RD_E;
      r_pc_plus4_m   <= PCPlus4E;
      r_write_data_m <= w_fwd_b;
      r_alu_result_m <= w_mul_done ? w_mul_result : w_alu_result;
    end
  end

  assign RegWriteM   = r_reg_write_m;
  assign MemWriteM   = r_mem_write_m;
  assign ResultSrcM  = r_result_src_m;
  assign RD_M        = r_rd_m;
  assign PCPlus4M    = r_pc_plus4_m;
  assign WriteDataM  = r_write_data_m;
  assign ALU_ResultM = r_alu_result_m;

endmodule

// File: tb/tb_execute_stage_fwd.sv
// tb_execute_stage_fwd
// Directed bench for execute_stage_fwd (XLEN=32) with a behavioural model
// checked every cycle and literal expectations on key transactions.
module tb_execute_stage_fwd;
  import riscv_ex_pkg::*;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              RegWriteE, MemWriteE, ResultSrcE, ALUSrcE;
  logic              BranchE, JumpE, JalrE, MulE;
  logic [2:0]        BranchTypeE;
  logic [1:0]        MulOpE;
  logic [3:0]        ALUControlE;
  logic [1:0]        ForwardAE, ForwardBE;
  logic [XLEN-1:0]   RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [REG_AW-1:0] RD_E;
  logic              PCSrcE, busy_e, RegWriteM, MemWriteM, ResultSrcM;
  logic [XLEN-1:0]   PCTargetE, PCPlus4M, WriteDataM, ALU_ResultM;
  logic [REG_AW-1:0] RD_M;

  int n_tests = 0;
  int n_fail  = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  execute_stage_fwd #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .ALUSrcE(ALUSrcE), .BranchE(BranchE), .JumpE(JumpE), .JalrE(JalrE),
    .MulE(MulE), .BranchTypeE(BranchTypeE), .MulOpE(MulOpE),
    .ALUControlE(ALUControlE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE),
    .PCPlus4E(PCPlus4E), .RD_E(RD_E), .ResultW(ResultW),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .busy_e(busy_e),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM),
    .ALU_ResultM(ALU_ResultM)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] f_fwd(input logic [1:0] sel, input logic [31:0] rd,
                                        input logic [31:0] w, input logic [31:0] m);
    if (sel == 2'b01) return w;
    if (sel == 2'b10) return m;
    return rd;
  endfunction

  function automatic logic [31:0] f_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    longint sa;
    sh = int'(b[4:0]);
    sa = longint'($signed(a));
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLL:  return a << sh;
      ALU_SRL:  return a >> sh;
      ALU_SRA:  begin sa = sa >>> sh; return sa[31:0]; end
      ALU_SLT:  return (sa < longint'($signed(b))) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic logic f_taken(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (t)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return sa < sb;
      3'b101:  return sa >= sb;
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] f_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    case (op)
      2'b00, 2'b01: p = sa * sb;
      2'b10:        p = sa * ub;
      default:      p = {32'd0, a} * {32'd0, b};
    endcase
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  logic        m_reg_write = 0, m_mem_write = 0, m_result_src = 0, m_bubble = 0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_pc4 = '0, m_wd = '0, m_alu = '0, m_mul_res = '0;
  int          m_cnt = 0;  // cycles left until the multiply result is loaded

  logic [31:0] e_fa, e_fb, e_sb;
  assign e_fa = f_fwd(ForwardAE, RD1_E, ResultW, m_alu);
  assign e_fb = f_fwd(ForwardBE, RD2_E, ResultW, m_alu);
  assign e_sb = ALUSrcE ? Imm_Ext_E : e_fb;

  always @(posedge clk) begin
    if (rst) begin
      {m_reg_write, m_mem_write, m_result_src} <= 3'b000;
      m_rd <= '0; m_pc4 <= '0; m_wd <= '0; m_alu <= '0;
      m_bubble <= 1'b0;
      m_cnt <= 0;
    end else if ((m_cnt == 0 && MulE) || m_cnt > 1) begin
      {m_reg_write, m_mem_write, m_result_src} <= 3'b000;
      m_bubble <= 1'b1;
      if (m_cnt == 0) begin
        m_cnt     <= XLEN + 1;
        m_mul_res <= f_mul(MulOpE, e_fa, e_fb);
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else begin
      m_reg_write  <= RegWriteE;
      m_mem_write  <= MemWriteE;
      m_result_src <= ResultSrcE;
      m_rd         <= RD_E;
      m_pc4        <= PCPlus4E;
      m_wd         <= e_fb;
      m_alu        <= (m_cnt == 1) ? m_mul_res : f_alu(ALUControlE, e_fa, e_sb);
      m_bubble     <= 1'b0;
      m_cnt        <= 0;
    end
  end

  // Compare process: combinational outputs against the current inputs,
  // registered outputs against the model's EX/MEM contents.
  always @(negedge clk) begin
    if (check_en) begin
      chk("busy_e", busy_e, (m_cnt == 0 && MulE) || m_cnt > 1);
      chk("PCSrcE", PCSrcE, (BranchE && f_taken(BranchTypeE, e_fa, e_fb)) || JumpE);
      chk("PCTargetE", PCTargetE, JalrE ? ((e_fa + Imm_Ext_E) & 32'hFFFF_FFFE) : (PCE + Imm_Ext_E));
      chk("RegWriteM", RegWriteM, m_reg_write);
      chk("MemWriteM", MemWriteM, m_mem_write);
      chk("ResultSrcM", ResultSrcM, m_result_src);
      if (!m_bubble) begin
        chk("RD_M", RD_M, m_rd);
        chk("PCPlus4M", PCPlus4M, m_pc4);
        chk("WriteDataM", WriteDataM, m_wd);
        chk("ALU_ResultM", ALU_ResultM, m_alu);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop();
    {RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, JumpE, JalrE, MulE} = 8'd0;
    BranchTypeE = 3'b010; MulOpE = 2'b00; ALUControlE = ALU_ADD;
    ForwardAE = 2'b00; ForwardBE = 2'b00;
    RD1_E = '0; RD2_E = '0; Imm_Ext_E = '0; PCE = 32'h40; PCPlus4E = 32'h44;
    RD_E = '0; ResultW = 32'h0BAD;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic alusrc, input logic [1:0] fa);
    set_nop();
    RegWriteE = 1'b1; RD_E = 5'd3; ALUControlE = op;
    RD1_E = a; RD2_E = b; Imm_Ext_E = imm; ALUSrcE = alusrc; ForwardAE = fa;
    cyc();
  endtask

  task automatic do_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] lit);
    int busy_cnt;
    set_nop();
    MulE = 1'b1; MulOpE = op; RegWriteE = 1'b1; RD_E = 5'd9; PCPlus4E = 32'h300;
    ForwardAE = 2'b01; ResultW = a; RD1_E = ~a; RD2_E = b;
    busy_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!busy_e) break;
      busy_cnt++;
      cyc();
      ResultW = 32'h1234_5678;  // operand already latched
    end
    cyc();
    $display("[TB] mul op=%0d a=%h b=%h -> %h (busy %0d cycles)", op, a, b, ALU_ResultM, busy_cnt);
    chk("mul_busy_cycles", 64'(busy_cnt), 64'd33);
    chk("mul_result", ALU_ResultM, lit);
    chk("mul_regwrite", RegWriteM, 1'b1);
    set_nop();
  endtask

  logic [3:0]  t_op [10] = '{ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_ADD};
  logic [31:0] t_a  [10] = '{32'd5, 32'hF0F0, 32'hF0F0, 32'hF0F0, 32'd1, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] t_b  [10] = '{32'd7, 32'hFF00, 32'hFF00, 32'hFF00, 32'h3F, 32'd4, 32'd4, 32'd1, 32'd1, 32'd2};
  logic [31:0] t_r  [10] = '{32'hFFFF_FFFE, 32'hF000, 32'hFFF0, 32'h0FF0, 32'h8000_0000, 32'h0800_0000, 32'hF800_0000, 32'd1, 32'd0, 32'd1};
  logic [2:0]  b_typ [7] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010};
  logic        b_exp [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    set_nop();
    rst = 1'b1;
    MulE = 1'b1;  // reset must dominate a pending multiply request
    cyc(); cyc();
    MulE = 1'b0;
    #1;
    $display("[TB] reset");
    chk("rst_busy", busy_e, 1'b0);
    chk("rst_regwrite", RegWriteM, 1'b0);
    chk("rst_memwrite", MemWriteM, 1'b0);
    chk("rst_resultsrc", ResultSrcM, 1'b0);
    chk("rst_rd", RD_M, 5'd0);
    chk("rst_pc4", PCPlus4M, 32'd0);
    chk("rst_wd", WriteDataM, 32'd0);
    chk("rst_alu", ALU_ResultM, 32'd0);
    rst = 1'b0;
    check_en = 1'b1;

    // forward from MEM: previous result 5, RD1=9 ignored -> 5+3
    issue(ALU_ADD, 32'd2, 32'd0, 32'd3, 1'b1, 2'b00);
    $display("[TB] add 2+3 -> %h", ALU_ResultM);
    chk("add_imm", ALU_ResultM, 32'd5);
    issue(ALU_ADD, 32'd9, 32'd0, 32'd3, 1'b1, 2'b10);
    $display("[TB] fwdM add -> %h", ALU_ResultM);
    chk("fwd_mem_add", ALU_ResultM, 32'd8);

    // store with B forwarded from WB; WriteData is fwdB, not the immediate
    set_nop();
    MemWriteE = 1'b1; ForwardBE = 2'b01; ResultW = 32'hAA; RD2_E = 32'h55;
    RD1_E = 32'h100; Imm_Ext_E = 32'd4; ALUSrcE = 1'b1;
    cyc();
    $display("[TB] store wd=%h addr=%h mw=%b", WriteDataM, ALU_ResultM, MemWriteM);
    chk("store_wd", WriteDataM, 32'hAA);
    chk("store_mw", MemWriteM, 1'b1);
    chk("store_addr", ALU_ResultM, 32'h104);

    // ALU table, A via select 11 (falls back to RD1)
    for (int i = 0; i < 10; i++) begin
      issue(t_op[i], t_a[i], t_b[i], 32'h0, 1'b0, 2'b11);
      $display("[TB] alu op=%0d a=%h b=%h -> %h", t_op[i], t_a[i], t_b[i], ALU_ResultM);
      chk("alu_table", ALU_ResultM, t_r[i]);
    end

    // branch compare: fwdA=-1, fwdB=1
    set_nop();
    BranchE = 1'b1; RD1_E = 32'hFFFF_FFFF; RD2_E = 32'd1; PCE = 32'h100; Imm_Ext_E = 32'h20;
    for (int i = 0; i < 7; i++) begin
      BranchTypeE = b_typ[i];
      #1;
      $display("[TB] branch type=%b -> pcsrc=%b tgt=%h", b_typ[i], PCSrcE, PCTargetE);
      chk("branch_taken", PCSrcE, b_exp[i]);
      chk("branch_target", PCTargetE, 32'h120);
    end
    cyc();

    // JAL then JALR
    set_nop();
    JumpE = 1'b1; RegWriteE = 1'b1; RD_E = 5'd1; PCE = 32'h200; PCPlus4E = 32'h204;
    RD1_E = 32'h1001; Imm_Ext_E = 32'd2;
    #1;
    chk("jal_target", PCTargetE, 32'h202);
    JalrE = 1'b1;
    #1;
    $display("[TB] jalr -> pcsrc=%b tgt=%h", PCSrcE, PCTargetE);
    chk("jalr_target", PCTargetE, 32'h1002);
    chk("jalr_pcsrc", PCSrcE, 1'b1);
    cyc();
    chk("jalr_pc4", PCPlus4M, 32'h204);
    chk("jalr_rd", RD_M, 5'd1);

    // multiplies
    do_mul(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
    do_mul(2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0);
    do_mul(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    do_mul(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_mul(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    do_mul(2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB);
    do_mul(2'b11, 32'h8000_0000, 32'd2, 32'h1);

    // reset during RUN aborts the multiply
    set_nop();
    MulE = 1'b1; MulOpE = 2'b01; RD1_E = 32'd3; RD2_E = 32'd5; RegWriteE = 1'b1;
    repeat (11) cyc();
    rst = 1'b1;
    set_nop();
    cyc();
    $display("[TB] reset mid-multiply busy=%b regwrite=%b", busy_e, RegWriteM);
    chk("abort_busy", busy_e, 1'b0);
    chk("abort_regwrite", RegWriteM, 1'b0);
    chk("abort_alu", ALU_ResultM, 32'd0);
    chk("abort_rd", RD_M, 5'd0);
    rst = 1'b0;
    issue(ALU_ADD, 32'd1, 32'd2, 32'd0, 1'b0, 2'b00);
    $display("[TB] add after abort -> %h", ALU_ResultM);
    chk("post_abort_add", ALU_ResultM, 32'd3);

    set_nop();
    cyc(); cyc();
    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
